// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core requesters (fetch, data), the arbiter and the unified memory port.
// The arbiter uses the slave modport; the environment (requesters plus memory) uses master.
interface mem_arbiter_if #(
    parameter int N = 64,
    parameter int W = 32
);
    logic          if_req;
    logic [W-1:0]  if_addr;
    logic [W-1:0]  if_rdata;
    logic          if_ready;
    logic          dm_req;
    logic [1:0]    dm_we;
    logic [N-1:0]  dm_addr;
    logic [N-1:0]  dm_wdata;
    logic [N-1:0]  dm_rdata;
    logic          dm_ready;
    logic          mem_req;
    logic [1:0]    mem_we;
    logic [N-1:0]  mem_addr;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata;
    logic          mem_ack;
    logic          busy;
    logic          grant_d;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
               busy, grant_d
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
               busy, grant_d
    );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the unified memory port between fetch and data: data has fixed priority,
// bounded by a consecutive-grant counter so a waiting fetch is served after at most MAXD data accesses.
module mem_arbiter #(
    parameter int N    = 64,
    parameter int W    = 32,
    parameter int MAXD = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int DCW = $clog2(MAXD + 1);
    localparam logic [DCW-1:0] DMAX = DCW'(MAXD);
    localparam logic [DCW-1:0] DONE = DCW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DACC = 2'd1,
        IACC = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DCW-1:0]  dcnt_q, dcnt_d;
    logic            mem_req_q, mem_req_d;
    logic [1:0]      mem_we_q, mem_we_d;
    logic [N-1:0]    mem_addr_q, mem_addr_d;
    logic [N-1:0]    mem_wdata_q, mem_wdata_d;
    logic [N-1:0]    dm_rdata_q, dm_rdata_d;
    logic [W-1:0]    if_rdata_q, if_rdata_d;
    logic            dm_ready_q, dm_ready_d;
    logic            if_ready_q, if_ready_d;
    logic            busy_q, busy_d;
    logic            grant_d_q, grant_d_d;

    // Next-state, grant decision and response capture
    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_rdata_d  = if_rdata_q;
        dm_ready_d  = 1'b0;
        if_ready_d  = 1'b0;
        grant_d_d   = grant_d_q;
        case (state_q)
            IDLE: begin
                if (bus.dm_req && (!bus.if_req || (dcnt_q < DMAX))) begin
                    state_d     = DACC;
                    grant_d_d   = 1'b1;
                    dcnt_d      = bus.if_req ? (dcnt_q + DONE) : {DCW{1'b0}};
                    mem_req_d   = 1'b1;
                    // Reserved write type 11 is issued as a plain read
                    mem_we_d    = (bus.dm_we == 2'b11) ? 2'b00 : bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                end else if (bus.if_req) begin
                    state_d     = IACC;
                    grant_d_d   = 1'b0;
                    dcnt_d      = {DCW{1'b0}};
                    mem_req_d   = 1'b1;
                    mem_we_d    = 2'b00;
                    mem_addr_d  = N'(bus.if_addr);
                    mem_wdata_d = {N{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            DACC: begin
                if (bus.mem_ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    dm_rdata_d = bus.mem_rdata;
                    dm_ready_d = 1'b1;
                end else begin
                    state_d = DACC;
                end
            end
            IACC: begin
                if (bus.mem_ack) begin
                    state_d    = RESP;
                    mem_req_d  = 1'b0;
                    if_rdata_d = bus.mem_rdata[W-1:0];
                    if_ready_d = 1'b1;
                end else begin
                    state_d = IACC;
                end
            end
            // Ready pulses here; held requests are not re-arbitrated until IDLE
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and registered-output flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            dcnt_q      <= {DCW{1'b0}};
            mem_req_q   <= 1'b0;
            mem_we_q    <= 2'b00;
            mem_addr_q  <= {N{1'b0}};
            mem_wdata_q <= {N{1'b0}};
            dm_rdata_q  <= {N{1'b0}};
            if_rdata_q  <= {W{1'b0}};
            dm_ready_q  <= 1'b0;
            if_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            grant_d_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            dcnt_q      <= dcnt_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_ready_q  <= dm_ready_d;
            if_ready_q  <= if_ready_d;
            busy_q      <= busy_d;
            grant_d_q   <= grant_d_d;
        end
    end

    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_ready  = dm_ready_q;
    assign bus.if_ready  = if_ready_q;
    assign bus.busy      = busy_q;
    assign bus.grant_d   = grant_d_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single transactions, hand-written multi-cycle
// sequences, then random traffic against a transaction-level reference model.
module tb_mem_arbiter;
    localparam int N    = 64;
    localparam int W    = 32;
    localparam int MAXD = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.N(N), .W(W)) bus ();
    mem_arbiter #(.N(N), .W(W), .MAXD(MAXD)) dut (.clk(clk), .reset(reset), .bus(bus));

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic        fetch;
        logic [1:0]  we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          lat;
        logic [1:0]  e_we;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic [63:0] e_rdata;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'h0;
        bus.dm_req    = 1'b0;
        bus.dm_we     = 2'b00;
        bus.dm_addr   = 64'h0;
        bus.dm_wdata  = 64'h0;
        bus.mem_rdata = 64'h0;
        bus.mem_ack   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    // One isolated transaction: request in cycle 0, ack in cycle 1+lat, ready in cycle 2+lat
    task automatic run_vec(input vec_t v, input int idx);
        logic [63:0] prev_other;
        cyc();
        if (v.fetch) begin
            bus.if_req  = 1'b1;
            bus.if_addr = v.addr[31:0];
        end else begin
            bus.dm_req   = 1'b1;
            bus.dm_we    = v.we;
            bus.dm_addr  = v.addr;
            bus.dm_wdata = v.wdata;
        end
        smp();
        chk($sformatf("v%0d busy_c0", idx), 64'(bus.busy), 64'd0);
        prev_other = v.fetch ? bus.dm_rdata : 64'(bus.if_rdata);
        for (int k = 0; k <= v.lat; k++) begin
            cyc();
            bus.mem_ack   = (k == v.lat);
            bus.mem_rdata = (k == v.lat) ? v.rdata : {$urandom, $urandom};
            smp();
            chk($sformatf("v%0d mem_req_c%0d", idx, k + 1), 64'(bus.mem_req), 64'd1);
            if (k == 0) begin
                chk($sformatf("v%0d mem_we", idx), 64'(bus.mem_we), 64'(v.e_we));
                chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.e_addr);
                chk($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.e_wdata);
                chk($sformatf("v%0d grant_d", idx), 64'(bus.grant_d), 64'(!v.fetch));
            end
        end
        cyc();
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        bus.dm_req  = 1'b0;
        smp();
        chk($sformatf("v%0d dm_ready", idx), 64'(bus.dm_ready), 64'(!v.fetch));
        chk($sformatf("v%0d if_ready", idx), 64'(bus.if_ready), 64'(v.fetch));
        chk($sformatf("v%0d rdata", idx), v.fetch ? 64'(bus.if_rdata) : bus.dm_rdata, v.e_rdata);
        chk($sformatf("v%0d other_rdata", idx), v.fetch ? bus.dm_rdata : 64'(bus.if_rdata), prev_other);
        chk($sformatf("v%0d mem_req_resp", idx), 64'(bus.mem_req), 64'd0);
        cyc();
        smp();
        chk($sformatf("v%0d busy_after", idx), 64'(bus.busy), 64'd0);
        chk($sformatf("v%0d ready_after", idx), 64'({bus.dm_ready, bus.if_ready}), 64'd0);
        chk($sformatf("v%0d rdata_hold", idx), v.fetch ? 64'(bus.if_rdata) : bus.dm_rdata, v.e_rdata);
    endtask

    // Reference model state for the random phase
    bit          tx_valid, tx_acked, tx_data;
    logic [1:0]  tx_we;
    logic [63:0] tx_addr, tx_wdata;
    logic [63:0] m_dm_rdata;
    logic [31:0] m_if_rdata;
    bit          m_grant_d;
    int          m_streak;
    bit          drop_dm, drop_if;

    initial begin
        logic [9:0] order;
        int         ng;
        bit         in_acc, in_resp;

        tbl[0] = '{1'b0, 2'b10, 64'h7, 64'hAB, 64'h55, 0, 2'b10, 64'h7, 64'hAB, 64'h55};
        tbl[1] = '{1'b1, 2'b00, 64'h40, 64'h0, 64'h8C010004, 2, 2'b00, 64'h40, 64'h0, 64'h8C010004};
        tbl[2] = '{1'b0, 2'b00, 64'hFFFF_0000_1234_5678, 64'h0, 64'hDEADBEEF_CAFEF00D, 1,
                   2'b00, 64'hFFFF_0000_1234_5678, 64'h0, 64'hDEADBEEF_CAFEF00D};
        tbl[3] = '{1'b0, 2'b11, 64'h20, 64'h0, 64'h1, 0, 2'b00, 64'h20, 64'h0, 64'h1};
        tbl[4] = '{1'b1, 2'b00, 64'hFFFF_FFFC, 64'h0, 64'hAAAAAAAA_13579BDF, 3,
                   2'b00, 64'hFFFF_FFFC, 64'h0, 64'h13579BDF};
        tbl[5] = '{1'b0, 2'b01, 64'h100, 64'h1234, 64'h0, 0, 2'b01, 64'h100, 64'h1234, 64'h0};

        // Reset with both requests asserted, then data wins the first grant
        idle_inputs();
        reset = 1'b1;
        cyc();
        bus.if_req  = 1'b1;
        bus.dm_req  = 1'b1;
        bus.dm_we   = 2'b01;
        bus.dm_addr = 64'h8;
        reset       = 1'b0;
        smp();
        chk("rst outputs", {bus.mem_req, bus.busy, bus.grant_d, bus.dm_ready, bus.if_ready,
                            bus.mem_we, 57'(bus.mem_addr | bus.mem_wdata | bus.dm_rdata)}, 64'd0);
        chk("rst if_rdata", 64'(bus.if_rdata), 64'd0);
        cyc();
        reset = 1'b1;
        smp();
        chk("rel c0 mem_req", 64'(bus.mem_req), 64'd0);
        cyc();
        smp();
        chk("rel c1 mem_req", 64'(bus.mem_req), 64'd1);
        chk("rel c1 grant_d", 64'(bus.grant_d), 64'd1);
        chk("rel c1 mem_we", 64'(bus.mem_we), 64'd1);

        do_reset();
        for (int i = 0; i < 6; i++) run_vec(tbl[i], i);

        // Simultaneous requests: data first, fetch granted after the response cycle
        do_reset();
        cyc();
        bus.if_req   = 1'b1;
        bus.if_addr  = 32'h80;
        bus.dm_req   = 1'b1;
        bus.dm_we    = 2'b01;
        bus.dm_addr  = 64'h100;
        bus.dm_wdata = 64'h1234;
        cyc();
        bus.mem_ack = 1'b1;
        smp();
        chk("both c1 grant", 64'({bus.mem_req, bus.grant_d, bus.mem_we}), 64'b1101);
        chk("both c1 addr", bus.mem_addr, 64'h100);
        cyc();
        bus.mem_ack = 1'b0;
        bus.dm_req  = 1'b0;
        smp();
        chk("both c2 ready", 64'({bus.dm_ready, bus.if_ready}), 64'b10);
        cyc();
        smp();
        chk("both c3 idle", 64'({bus.mem_req, bus.dm_ready}), 64'd0);
        cyc();
        bus.mem_ack = 1'b1;
        smp();
        chk("both c4 fetch", 64'({bus.mem_req, bus.grant_d, bus.mem_we}), 64'b1000);
        chk("both c4 addr", bus.mem_addr, 64'h80);
        cyc();
        bus.mem_ack = 1'b0;
        bus.if_req  = 1'b0;
        smp();
        chk("both c5 ready", 64'({bus.dm_ready, bus.if_ready}), 64'b01);

        // Both held, immediate ack: starvation bound shapes the grant order
        do_reset();
        cyc();
        bus.if_req = 1'b1;
        bus.dm_req = 1'b1;
        ng = 0;
        order = '0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            cyc();
            bus.mem_ack = bus.mem_req;
            smp();
            if (bus.mem_req) begin
                order[ng] = bus.grant_d;
                ng++;
            end
        end
        chk("starve grant count", 64'(ng), 64'd10);
        for (int i = 0; i < 10; i++)
            chk($sformatf("starve grant%0d", i), 64'(order[i]), 64'((i % 5) != 4));

        // Reset during a data access; a late ack afterwards must be ignored
        do_reset();
        cyc();
        bus.dm_req  = 1'b1;
        bus.dm_addr = 64'h30;
        cyc();
        smp();
        chk("midrst mem_req before", 64'(bus.mem_req), 64'd1);
        #2;
        reset       = 1'b0;
        bus.dm_req  = 1'b0;
        #1;
        chk("midrst mem_req async", 64'({bus.mem_req, bus.busy}), 64'd0);
        cyc();
        reset = 1'b1;
        cyc();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'hFEED;
        smp();
        chk("midrst late ack c0", 64'({bus.dm_ready, bus.mem_req}), 64'd0);
        cyc();
        bus.mem_ack = 1'b0;
        smp();
        chk("midrst late ack c1", 64'({bus.dm_ready, bus.busy, bus.mem_req}), 64'd0);
        chk("midrst dm_rdata", bus.dm_rdata, 64'd0);

        // Random traffic against the transaction-level model
        do_reset();
        tx_valid = 1'b0; tx_acked = 1'b0; tx_data = 1'b0;
        tx_we = 2'b00; tx_addr = 64'h0; tx_wdata = 64'h0;
        m_dm_rdata = 64'h0; m_if_rdata = 32'h0; m_grant_d = 1'b0; m_streak = 0;
        drop_dm = 1'b0; drop_if = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            cyc();
            if (drop_dm) bus.dm_req = 1'b0;
            if (drop_if) bus.if_req = 1'b0;
            if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
                bus.dm_req   = 1'b1;
                bus.dm_we    = 2'($urandom);
                bus.dm_addr  = {$urandom, $urandom};
                bus.dm_wdata = {$urandom, $urandom};
            end
            if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req  = 1'b1;
                bus.if_addr = $urandom;
            end
            in_acc  = tx_valid && !tx_acked;
            in_resp = tx_valid && tx_acked;
            bus.mem_ack   = in_acc ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            bus.mem_rdata = {$urandom, $urandom};
            smp();
            chk("rnd mem_req", 64'(bus.mem_req), 64'(in_acc));
            chk("rnd busy", 64'(bus.busy), 64'(tx_valid));
            chk("rnd dm_ready", 64'(bus.dm_ready), 64'(in_resp && tx_data));
            chk("rnd if_ready", 64'(bus.if_ready), 64'(in_resp && !tx_data));
            chk("rnd dm_rdata", bus.dm_rdata, m_dm_rdata);
            chk("rnd if_rdata", 64'(bus.if_rdata), 64'(m_if_rdata));
            chk("rnd grant_d", 64'(bus.grant_d), 64'(m_grant_d));
            if (in_acc) begin
                chk("rnd mem_we", 64'(bus.mem_we), 64'(tx_we));
                chk("rnd mem_addr", bus.mem_addr, tx_addr);
                chk("rnd mem_wdata", bus.mem_wdata, tx_wdata);
            end
            drop_dm = in_resp && tx_data;
            drop_if = in_resp && !tx_data;
            if (in_acc && bus.mem_ack) begin
                tx_acked = 1'b1;
                if (tx_data) m_dm_rdata = bus.mem_rdata;
                else         m_if_rdata = bus.mem_rdata[31:0];
            end else if (in_resp) begin
                tx_valid = 1'b0;
            end else if (!tx_valid) begin
                if (bus.dm_req && (!bus.if_req || m_streak < MAXD)) begin
                    tx_valid = 1'b1; tx_acked = 1'b0; tx_data = 1'b1; m_grant_d = 1'b1;
                    tx_we    = (bus.dm_we == 2'b11) ? 2'b00 : bus.dm_we;
                    tx_addr  = bus.dm_addr;
                    tx_wdata = bus.dm_wdata;
                    m_streak = bus.if_req ? m_streak + 1 : 0;
                end else if (bus.if_req) begin
                    tx_valid = 1'b1; tx_acked = 1'b0; tx_data = 1'b0; m_grant_d = 1'b0;
                    tx_we    = 2'b00;
                    tx_addr  = {32'h0, bus.if_addr};
                    tx_wdata = 64'h0;
                    m_streak = 0;
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
